shift_input_conditioner: RTL and testbench
==========================================

# shift_input_conditioner

Front-end stage that synchronizes and debounces the raw board inputs (16 switches, direction switch, 4 push-buttons) and presents a clean, registered shift command to the 16-bit barrel shifter. It sits between the FPGA pins and the shifter instance in `top`. It also produces a one-cycle `cmd_valid` pulse whenever the command changes, for downstream capture or display logic.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before an input change is accepted (10 ms at 100 MHz). Must be ≥ 2.
- `clk` in 1: system clock, single clock domain.
- `n_rst` in 1: asynchronous, active-low reset.
- `sw_raw` in 16: raw switch inputs, asynchronous to `clk`.
- `lr_raw` in 1: raw direction switch, asynchronous.
- `btn_raw` in 4: raw push-buttons, asynchronous.
- `num` out 16: conditioned operand to the shifter.
- `amt` out 4: conditioned shift amount to the shifter.
- `lr` out 1: conditioned direction to the shifter.
- `cmd_valid` out 1: one-cycle pulse after any bit of `{num, amt, lr}` changes.

## Operation
- The 21 input bits are processed independently. Bit order is `{sw, lr, btn}`.
- Each bit passes through a 2-flop synchronizer (`s1`, then `s2`).
- Debounce per bit:
  - State is `stable` (1 bit) plus a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - `s2 == stable`: `cnt` clears to 0.
  - `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` increments.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt` clears.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles clears `cnt` and produces no output change.
- Outputs `num`, `amt` and `lr` are the `stable` registers directly. There is no extra output stage.
- `cmd_valid` is registered. It is high for exactly one cycle after any edge where at least one `stable` bit toggled.
  - Several bits settling on the same edge produce one pulse.
  - Bits settling on different edges produce one pulse each, and back-to-back pulses are allowed.
- Reset (`n_rst` low, asynchronous): all sync flops, `stable`, `cnt` and `cmd_valid` go to 0. Therefore `num`=0, `amt`=0, `lr`=0, `cmd_valid`=0.
- Reset mid-count discards the partial count. After release, a raw input that is already high is accepted as a change from 0 and produces one `cmd_valid` pulse.

## Timing
- Let raw bit change be sampled into `s1` at edge 0 and held steady.
  - `s2` updates at edge 1.
  - `cnt` increments at edges 2 … D.
  - `stable` (the output) updates at edge D+1, where D = `DEBOUNCE_CYCLES`.
- `cmd_valid` is high in the cycle following edge D+1. It is set on the same edge that updates `stable`, so the output and the pulse are coincident.
- Outputs are glitch-free because each is a single flop with no combinational path from the pins.
- No backpressure: the downstream stage samples `cmd_valid` or uses the outputs continuously.

## Configuration
- `SHIFT_COND_SW_DEBOUNCE_EN`:
  - Defined: all 21 bits are synchronized and debounced as above.
  - Undefined: the 16 `sw` bits are synchronized only. `num` equals `s2` registered one more edge, giving a latency of 3 edges and no debounce counter. `lr` and `btn` are still debounced.
  - `cmd_valid` still pulses on any `num` change in both builds.

## Structure
- Package `shift_cond_pkg` holds:
  - the `NUM_W` = 16 and `AMT_W` = 4 constants;
  - the typedef `shift_cmd_t` (packed struct `{num, amt, lr}`);
  - the default debounce constant.
- Sub-module `debounce_bit` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `n_rst`, `din`, `dout`, `changed`) contains the synchronizer, counter and `stable` register. The top level instantiates 21 of these in a generate loop, ORs the `changed` signals and registers the result into `cmd_valid`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset:** assert `n_rst` with `sw_raw`=16'hFFFF → all outputs 0 immediately. Release reset → `num`=16'hFFFF at edge 5 and a single `cmd_valid` pulse.
- **Clean press:** `btn_raw` 0→4'b0101, held → `amt`=4'h5 exactly at edge 5 after sampling, `cmd_valid` high for 1 cycle, then `amt` stays 4'h5.
- **Bounce:** `lr_raw` toggles 1,0,1,0 every 2 cycles, then stays 1 → `lr` rises only 5 edges after the final rising sample, with exactly one `cmd_valid` pulse.
- **Simultaneous:** `sw_raw`=16'hA5A5 and `btn_raw`=4'h3 change on the same edge → both outputs update on the same edge with a single one-cycle `cmd_valid` pulse.
- **Mid-count reset:** change `sw_raw` and pulse `n_rst` low at count 2 → outputs stay 0 during reset. After release, the full D+1 latency restarts.
- **Macro off:** with `SHIFT_COND_SW_DEBOUNCE_EN` undefined, `sw_raw`=16'h0001 → `num`=16'h0001 after 3 edges with a `cmd_valid` pulse.

Source files
------------

// File: rtl/shift_input_conditioner_pkg.sv
// Shared widths, command type and default debounce length for the shift input conditioner.
package shift_cond_pkg;

  localparam int unsigned NUM_W            = 16;
  localparam int unsigned AMT_W            = 4;
  localparam int unsigned IN_W             = NUM_W + 1 + AMT_W;
  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

  typedef struct packed {
    logic [NUM_W-1:0] num;
    logic [AMT_W-1:0] amt;
    logic             lr;
  } shift_cmd_t;

endpackage

// File: rtl/shift_input_conditioner_if.sv
// Board-pin side and shifter side of the input conditioner, bundled as one interface.
interface shift_input_conditioner_if;
  import shift_cond_pkg::*;

  logic [NUM_W-1:0] sw_raw;
  logic             lr_raw;
  logic [AMT_W-1:0] btn_raw;
  logic [NUM_W-1:0] num;
  logic [AMT_W-1:0] amt;
  logic             lr;
  logic             cmd_valid;

  modport master (
    output sw_raw, lr_raw, btn_raw,
    input  num, amt, lr, cmd_valid
  );

  modport slave (
    input  sw_raw, lr_raw, btn_raw,
    output num, amt, lr, cmd_valid
  );

endinterface

// File: rtl/shift_input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a consecutive-stable-cycles debouncer.
module debounce_bit
  import shift_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic dout,
  output logic changed
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // High exactly when stable is about to toggle on the coming edge.
  assign changed = (s2 != stable) && (cnt == CNT_MAX);
  assign dout    = stable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_input_conditioner.sv
// Synchronizes/debounces {sw, lr, btn} into a clean shift command plus a change pulse.
// Define SHIFT_COND_SW_DEBOUNCE_EN to debounce the switches too; otherwise they are sync-only.
module shift_input_conditioner
  import shift_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input logic                      clk,
  input logic                      n_rst,
  shift_input_conditioner_if.slave bus
);

  localparam int SW_LSB = int'(AMT_W) + 1;

  logic [IN_W-1:0] raw;
  logic [IN_W-1:0] clean;
  logic [IN_W-1:0] chg;
  shift_cmd_t      cmd;

  assign raw = {bus.sw_raw, bus.lr_raw, bus.btn_raw};

  for (genvar i = 0; i < int'(IN_W); i++) begin : g_bit
`ifndef SHIFT_COND_SW_DEBOUNCE_EN
    if (i >= SW_LSB) begin : g_sync
      // Switch bits: synchronizer plus one output flop, no debounce counter.
      logic s1;
      logic s2;
      logic q;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
          q  <= 1'b0;
        end else begin
          s1 <= raw[i];
          s2 <= s1;
          q  <= s2;
        end
      end

      assign clean[i] = q;
      assign chg[i]   = (s2 != q);
    end else begin : g_deb
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk    (clk),
        .n_rst  (n_rst),
        .din    (raw[i]),
        .dout   (clean[i]),
        .changed(chg[i])
      );
    end
`else
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .n_rst  (n_rst),
      .din    (raw[i]),
      .dout   (clean[i]),
      .changed(chg[i])
    );
`endif
  end

  assign cmd = {clean[IN_W-1 -: NUM_W], clean[AMT_W-1:0], clean[AMT_W]};

  assign bus.num = cmd.num;
  assign bus.amt = cmd.amt;
  assign bus.lr  = cmd.lr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.cmd_valid <= 1'b0;
    end else begin
      bus.cmd_valid <= |chg;
    end
  end

endmodule

// File: tb/tb_shift_input_conditioner.sv
// Bench for shift_input_conditioner with DEBOUNCE_CYCLES = 4: directed timing cases, a vector table and random stimulus.
module tb_shift_input_conditioner;

  localparam int D = 4;
  localparam int LAT = D + 1;
`ifdef SHIFT_COND_SW_DEBOUNCE_EN
  localparam int SW_LAT = D + 1;
  localparam bit SW_DEB = 1'b1;
`else
  localparam int SW_LAT = 2;
  localparam bit SW_DEB = 1'b0;
`endif
  localparam int SIM_PULSES = SW_DEB ? 1 : 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  shift_input_conditioner_if bus ();

  shift_input_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // Reference: raw samples per edge; an output bit flips once the last D
  // synchronized samples all disagree with it.
  logic [20:0] hist[$];
  logic [20:0] stab_m;
  logic        cv_m;

  typedef struct {
    logic [15:0] sw;
    logic        lr;
    logic [3:0]  btn;
    logic [15:0] e_num;
    logic [3:0]  e_amt;
    logic        e_lr;
  } vec_t;

  vec_t vec[6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back('0);
    stab_m = '0;
    cv_m   = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [20:0] nxt;
    logic        all_diff;
    int          n;
    nxt = stab_m;
    hist.push_back({bus.sw_raw, bus.lr_raw, bus.btn_raw});
    n = hist.size();
    for (int b = 0; b < 21; b++) begin
      if (b >= 5 && !SW_DEB) begin
        nxt[b] = hist[n-3][b];
      end else begin
        all_diff = 1'b1;
        for (int j = 3; j <= D + 2; j++)
          if (hist[n-j][b] == stab_m[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~stab_m[b];
      end
    end
    cv_m   = (nxt != stab_m);
    stab_m = nxt;
    void'(hist.pop_front());
  endfunction

  task automatic set_raw(input logic [20:0] v);
    bus.sw_raw  = v[20:5];
    bus.lr_raw  = v[4];
    bus.btn_raw = v[3:0];
  endtask

  task automatic step();
    @(posedge clk);
    if (n_rst) model_edge();
    else cv_m = 1'b0;
    @(negedge clk);
    chk("num", bus.num, stab_m[20:5]);
    chk("amt", bus.amt, stab_m[3:0]);
    chk("lr", bus.lr, stab_m[4]);
    chk("cmd_valid", bus.cmd_valid, cv_m);
    if (bus.cmd_valid) pulses++;
  endtask

  task automatic do_reset(input int cycles);
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("rst_num", bus.num, 0);
    chk("rst_amt", bus.amt, 0);
    chk("rst_lr", bus.lr, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    repeat (cycles) step();
    n_rst = 1'b1;
  endtask

  task automatic watch(input logic [15:0] tn, input logic [3:0] ta, input logic tl, input int n,
                       output int en, output int ea, output int el, output int np);
    int p0;
    en = -1; ea = -1; el = -1;
    p0 = pulses;
    for (int e = 0; e < n; e++) begin
      step();
      if (en < 0 && bus.num == tn) en = e;
      if (ea < 0 && bus.amt == ta) ea = e;
      if (el < 0 && bus.lr == tl) el = e;
    end
    np = pulses - p0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en, ea, el, np, p0, r, idx;
    logic [20:0] v;

    vec[0] = '{16'h0000, 1'b0, 4'h0, 16'h0000, 4'h0, 1'b0};
    vec[1] = '{16'hFFFF, 1'b1, 4'hF, 16'hFFFF, 4'hF, 1'b1};
    vec[2] = '{16'h8000, 1'b0, 4'h8, 16'h8000, 4'h8, 1'b0};
    vec[3] = '{16'h0001, 1'b1, 4'h1, 16'h0001, 4'h1, 1'b1};
    vec[4] = '{16'hAAAA, 1'b0, 4'hA, 16'hAAAA, 4'hA, 1'b0};
    vec[5] = '{16'h5555, 1'b1, 4'h5, 16'h5555, 4'h5, 1'b1};

    // Reset with switches already high: accepted as a change from 0 after release.
    set_raw({16'hFFFF, 1'b0, 4'h0});
    do_reset(3);
    watch(16'hFFFF, 4'h0, 1'b0, 10, en, ea, el, np);
    chk("reset_release_num_edge", en, SW_LAT);
    chk("reset_release_pulses", np, 1);

    // Clean button press.
    bus.btn_raw = 4'h5;
    watch(16'hFFFF, 4'h5, 1'b0, 10, en, ea, el, np);
    chk("press_amt_edge", ea, LAT);
    chk("press_pulses", np, 1);
    repeat (5) step();
    chk("press_amt_held", bus.amt, 4'h5);

    // Bouncing direction switch: 2-cycle glitches never reach the output.
    p0 = pulses;
    for (int k = 0; k < 4; k++) begin
      bus.lr_raw = (k % 2 == 0);
      repeat (2) step();
    end
    chk("bounce_glitch_pulses", pulses - p0, 0);
    chk("bounce_glitch_lr", bus.lr, 0);
    bus.lr_raw = 1'b1;
    watch(16'hFFFF, 4'h5, 1'b1, 10, en, ea, el, np);
    chk("bounce_lr_edge", el, LAT);
    chk("bounce_pulses", np, 1);

    // Switches and buttons change on the same edge.
    bus.sw_raw  = 16'hA5A5;
    bus.btn_raw = 4'h3;
    watch(16'hA5A5, 4'h3, 1'b1, 10, en, ea, el, np);
    chk("simul_num_edge", en, SW_LAT);
    chk("simul_amt_edge", ea, LAT);
    chk("simul_pulses", np, SIM_PULSES);

    // Reset in the middle of a count, then full latency from release.
    bus.sw_raw = 16'h1234;
    repeat (4) step();
    do_reset(2);
    watch(16'h1234, 4'h3, 1'b1, 10, en, ea, el, np);
    chk("midrst_num_edge", en, SW_LAT);
    chk("midrst_amt_edge", ea, LAT);
    chk("midrst_lr_edge", el, LAT);
    chk("midrst_pulses", np, SIM_PULSES);

    // Single low switch bit.
    bus.sw_raw = 16'h0001;
    watch(16'h0001, 4'h3, 1'b1, 10, en, ea, el, np);
    chk("sw_lsb_num_edge", en, SW_LAT);
    chk("sw_lsb_pulses", np, 1);

    // Vector table: hold each pattern long enough to settle.
    for (int t = 0; t < 6; t++) begin
      set_raw({vec[t].sw, vec[t].lr, vec[t].btn});
      repeat (8) step();
      chk("table_num", bus.num, vec[t].e_num);
      chk("table_amt", bus.amt, vec[t].e_amt);
      chk("table_lr", bus.lr, vec[t].e_lr);
    end

    // Random stimulus against the reference model.
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 39);
      v = {bus.sw_raw, bus.lr_raw, bus.btn_raw};
      if (r < 20) begin
      end else if (r < 32) begin
        idx = $urandom_range(0, 20);
        v[idx] = ~v[idx];
        set_raw(v);
      end else if (r < 38) begin
        v = 21'($urandom);
        set_raw(v);
      end else if (r == 38) begin
        do_reset($urandom_range(1, 3));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
